// File: rtl/seq_div_if.sv
// ----------------------------------------------------------------------------
// seq_div_if -- signal bundle between a requester and the seq_div divider.
//
// Handshake: the requester raises en for one cycle while the divider is idle
// (busy=0). The divider accepts it on that edge. Operands are read only on
// that edge. en seen while busy=1 is dropped and is not queued. The result
// (quot/rem/div_zero) is valid in the single cycle where data_rdy=1. There is
// no backpressure: the requester must take the result in that cycle. quot and
// rem then keep their value until the next result. abort cancels a division
// that is in flight.
//
// Signals (N = divisor width):
//   en, abort          requester -> divider, 1 bit each
//   dividend [2N-1:0]  requester -> divider
//   divisor  [N-1:0]   requester -> divider
//   quot     [2N-1:0]  divider -> requester
//   rem      [N-1:0]   divider -> requester
//   busy, data_rdy, div_zero   divider -> requester
// ----------------------------------------------------------------------------
interface seq_div_if #(
  parameter int N = 256
);
  logic           en;
  logic           abort;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] quot;
  logic [N-1:0]   rem;
  logic           busy;
  logic           data_rdy;
  logic           div_zero;

  modport master (
    output en, abort, dividend, divisor,
    input  quot, rem, busy, data_rdy, div_zero
  );

  modport slave (
    input  en, abort, dividend, divisor,
    output quot, rem, busy, data_rdy, div_zero
  );
endinterface

// File: rtl/seq_div.sv
// ----------------------------------------------------------------------------
// seq_div -- sequential unsigned restoring divider.
//
// The divider computes a 2N-bit dividend / N-bit divisor. It produces one
// quotient bit per clock, starting with the MSB. A full division takes 2N
// DIV cycles and is followed by one DONE cycle. In the DONE cycle data_rdy
// pulses and quot/rem are updated.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        seq_div_if.slave (en, abort, dividend, divisor -> quot, rem,
//              busy, data_rdy, div_zero)
//   state_dbg  current FSM state (0 IDLE, 1 DIV, 2 DONE)
//
// Optional macro SEQ_DIV_ZERO_DETECT_EN:
//   When the macro is defined, a start with divisor==0 goes straight to DONE.
//   The result is quot = all ones, rem = dividend[N-1:0], and div_zero is
//   high in that DONE cycle.
//   When the macro is not defined, a zero divisor runs the full iteration.
//   The iteration gives the same quot/rem, and div_zero is tied to 0.
// ----------------------------------------------------------------------------
module seq_div #(
  parameter int N = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_div_if.slave    bus,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(2 * N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;

  // Dividend bits shift out at the top. Quotient bits shift in at the bottom.
  // After 2N shifts this register holds the complete quotient.
  logic [2*N-1:0] dq_q;
  logic [N-1:0]   dvs_q;
  logic [N:0]     pr_q;      // partial remainder, one spare bit for the shift
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] quot_q;
  logic [N-1:0]   rem_q;

  logic [N:0]     pr_shift;
  logic [N:0]     pr_diff;
  logic           q_bit;
  logic           last_iter;
  logic           zero_fast;

`ifdef SEQ_DIV_ZERO_DETECT_EN
  assign zero_fast = (bus.divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit and compare.
  always_comb begin
    pr_shift  = {pr_q[N-1:0], dq_q[2*N-1]};
    pr_diff   = pr_shift - {1'b0, dvs_q};
    q_bit     = (pr_shift >= {1'b0, dvs_q});
    last_iter = (cnt_q == CW'(2 * N - 1));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state. In IDLE, en takes priority over abort. abort has an
  // effect only in DIV.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.en) state_d = zero_fast ? DONE : DIV;
      DIV: begin
        if (bus.abort)     state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_q   <= '0;
      dvs_q  <= '0;
      pr_q   <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            dq_q  <= bus.dividend;
            dvs_q <= bus.divisor;
            pr_q  <= '0;
            cnt_q <= '0;
            if (zero_fast) begin
              quot_q <= '1;
              rem_q  <= bus.dividend[N-1:0];
            end
          end
        end
        DIV: begin
          if (!bus.abort) begin
            dq_q  <= {dq_q[2*N-2:0], q_bit};
            pr_q  <= q_bit ? pr_diff : pr_shift;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
              quot_q <= {dq_q[2*N-2:0], q_bit};
              rem_q  <= q_bit ? pr_diff[N-1:0] : pr_shift[N-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quot     = quot_q;
  assign bus.rem      = rem_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.data_rdy = (state_q == DONE);
  assign state_dbg    = state_q;

`ifdef SEQ_DIV_ZERO_DETECT_EN
  // DONE with a captured zero divisor is reachable only through the fast path.
  assign bus.div_zero = (state_q == DONE) && (dvs_q == '0);
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

  localparam int N = 8;

`ifdef SEQ_DIV_ZERO_DETECT_EN
  localparam int   ZLAT  = 1;
  localparam logic ZFLAG = 1'b1;
`else
  localparam int   ZLAT  = 17;
  localparam logic ZFLAG = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_div_if #(.N(N)) bus ();
  logic [1:0] state_dbg;

  seq_div #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  int rdy_cnt  = 0;
  logic [3*N-1:0] exp_q[$];

  always @(negedge clk) if (bus.data_rdy) rdy_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: called at a negedge. en is high for exactly one posedge.
  task automatic launch(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs, input logic ab);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.en       = 1'b1;
    bus.abort    = ab;
    @(negedge clk);
    bus.en    = 1'b0;
    bus.abort = 1'b0;
  endtask

  // Counts edges, including the en edge, until data_rdy is seen. The wait is bounded.
  task automatic wait_rdy(output int edges, output logic busy_ok);
    edges   = 1;
    busy_ok = 1'b1;
    while (!bus.data_rdy && edges < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      edges++;
    end
  endtask

  // Scoreboard: pops the expected value and compares the result in the data_rdy cycle.
  task automatic score(input string tag, input int lat, input int exp_lat, input logic exp_dz);
    logic [3*N-1:0] e;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdy"}, bus.data_rdy, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_quot"}, bus.quot, e[3*N-1:N]);
    check({tag, "_rem"}, bus.rem, e[N-1:0]);
    check({tag, "_dz"}, bus.div_zero, exp_dz);
    @(negedge clk);
    check({tag, "_rdy_1cyc"}, bus.data_rdy, 1'b0);
    check({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic run_div(input string tag, input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                         input logic [2*N-1:0] eq, input logic [N-1:0] er,
                         input int exp_lat, input logic exp_dz);
    int lat;
    logic bok;
    exp_q.push_back({eq, er});
    launch(dvd, dvs, 1'b0);
    wait_rdy(lat, bok);
    check({tag, "_busy"}, bok, 1'b1);
    score(tag, lat, exp_lat, exp_dz);
  endtask

  initial begin
    int lat;
    int rc;
    logic bok;
    bus.en = 1'b0; bus.abort = 1'b0; bus.dividend = '0; bus.divisor = '0;

    // reset state
    #12;
    check("rst_quot", bus.quot, 16'h0);
    check("rst_rem", bus.rem, 8'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rdy", bus.data_rdy, 1'b0);
    check("rst_dz", bus.div_zero, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // main function
    run_div("basic", 16'h1234, 8'h07, 16'h0299, 8'h05, 17, 1'b0);
    run_div("div1", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 17, 1'b0);
    run_div("bigdvs", 16'h0005, 8'hFF, 16'h0000, 8'h05, 17, 1'b0);
    run_div("div0", 16'h00AB, 8'h00, 16'hFFFF, 8'hAB, ZLAT, ZFLAG);

    // en while busy is ignored
    exp_q.push_back({16'h0100, 8'h00});
    rc = rdy_cnt;
    launch(16'h1000, 8'h10, 1'b0);
    bok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!bus.busy) bok = 1'b0;
      @(negedge clk);
    end
    bus.dividend = 16'hFFFF; bus.divisor = 8'h03; bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    wait_rdy(lat, bok);
    check("busy_en_busy", bok, 1'b1);
    score("busy_en", lat, 12, 1'b0);
    repeat (20) @(negedge clk);
    check("busy_en_no2nd", rdy_cnt - rc, 1);
    check("busy_en_hold", bus.quot, 16'h0100);

    // abort at DIV cycle 8
    rc = rdy_cnt;
    launch(16'h4321, 8'h09, 1'b0);
    repeat (7) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_idle", bus.busy, 1'b0);
    repeat (20) @(negedge clk);
    check("abort_nordy", rdy_cnt - rc, 0);
    check("abort_quot", bus.quot, 16'h0100);
    check("abort_rem", bus.rem, 8'h00);
    run_div("after_abort", 16'h4321, 8'h09, 16'h0775, 8'h04, 17, 1'b0);

    // reset mid-DIV
    launch(16'h1234, 8'h07, 1'b0);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_quot", bus.quot, 16'h0);
    check("mrst_rem", bus.rem, 8'h0);
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_rdy", bus.data_rdy, 1'b0);
    check("mrst_dz", bus.div_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rc = rdy_cnt;
    repeat (40) @(negedge clk);
    check("mrst_nordy", rdy_cnt - rc, 0);
    check("mrst_idle", bus.busy, 1'b0);

    // first en after reset, with abort in the same IDLE cycle: en wins
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back({16'h000F, 8'h0F});
    launch(16'h00FF, 8'h10, 1'b1);
    check("en_abort_busy", bus.busy, 1'b1);
    wait_rdy(lat, bok);
    score("first_en", lat, 17, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
